// File: rtl/dram_io_nibble_seq_if.sv
// Controller-side request/response bundle for the DDR nibble-lane burst sequencer.
// master = DRAM controller datapath, slave = sequencer.
interface dram_io_nibble_seq_if;
    logic        burst_length_four;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [3:0]  rd_lat;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;

    modport master (
        output burst_length_four, wr_req, wr_data, rd_req, rd_lat,
        input  wr_ack, rd_ack, rd_data, rd_valid, busy
    );

    modport slave (
        input  burst_length_four, wr_req, wr_data, rd_req, rd_lat,
        output wr_ack, rd_ack, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/dram_io_nibble_seq.sv
// Burst sequencer for one DDR nibble lane: write serialisation with DQS pre/postamble,
// read window timing and beat gathering. Optional macro DRAM_IO_SEQ_LOOPBACK_CHK_EN adds lb_mismatch.
module dram_io_nibble_seq #(
    parameter int MAX_RD_LAT  = 15,
    parameter int WR_POST_CYC = 1
) (
    input  logic                 rclk,
    input  logic                 rst,
    dram_io_nibble_seq_if.slave  bus,
    input  logic [3:0]           io_dram_data_in,
    input  logic [3:0]           io_dram_data_in_hi,
    output logic [3:0]           data_pos,
    output logic [3:0]           data_neg,
    output logic                 dram_io_drive_enable,
    output logic                 dram_io_drive_data,
    output logic                 dqs_read
`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
    ,
    output logic                 lb_mismatch
`endif
);

    localparam int CNT_W = (MAX_RD_LAT < 3) ? 2 : $clog2(MAX_RD_LAT + 1);

    typedef enum logic [2:0] {IDLE, WPRE, WBURST, WPOST, RWAIT, RCAPT, RDONE} state_t;

    state_t            state_reg;
    logic              bl4_reg;
    logic [31:0]       wd_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        beat_reg;
    logic [23:0]       shadow_reg;
    logic [31:0]       rd_data_reg;
    logic              rd_valid_reg;
    logic [3:0]        data_pos_reg;
    logic [3:0]        data_neg_reg;
    logic              drive_enable_reg;
    logic              drive_data_reg;
    logic              dqs_read_reg;

    logic              accept_wr;
    logic              accept_rd;
    logic              last_beat;
    logic [31:0]       capt_word;

    // Acks are decided in the IDLE cycle itself so the requester sees them in the accept cycle.
    assign accept_wr = (state_reg == IDLE) && !rst && bus.wr_req;
    assign accept_rd = (state_reg == IDLE) && !rst && !bus.wr_req && bus.rd_req;
    assign last_beat = (beat_reg == (bl4_reg ? 2'd1 : 2'd3));
    // Beats shift in from the top, so after the last beat beat 0 sits in the lowest byte.
    assign capt_word = {io_dram_data_in_hi, io_dram_data_in, shadow_reg};

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_reg        <= IDLE;
            bl4_reg          <= 1'b0;
            wd_reg           <= '0;
            cnt_reg          <= '0;
            beat_reg         <= '0;
            shadow_reg       <= '0;
            rd_data_reg      <= '0;
            rd_valid_reg     <= 1'b0;
            data_pos_reg     <= '0;
            data_neg_reg     <= '0;
            drive_enable_reg <= 1'b0;
            drive_data_reg   <= 1'b0;
            dqs_read_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.wr_req) begin
                        state_reg        <= WPRE;
                        bl4_reg          <= bus.burst_length_four;
                        wd_reg           <= bus.wr_data;
                        drive_enable_reg <= 1'b1;
                    end else if (bus.rd_req) begin
                        bl4_reg      <= bus.burst_length_four;
                        dqs_read_reg <= 1'b1;
                        beat_reg     <= '0;
                        cnt_reg      <= CNT_W'(bus.rd_lat);
                        state_reg    <= (bus.rd_lat == 4'd0) ? RCAPT : RWAIT;
                    end
                end
                WPRE: begin
                    state_reg      <= WBURST;
                    beat_reg       <= '0;
                    drive_data_reg <= 1'b1;
                    data_pos_reg   <= wd_reg[3:0];
                    data_neg_reg   <= wd_reg[7:4];
                    wd_reg         <= wd_reg >> 8;
                end
                WBURST: begin
                    if (last_beat) begin
                        state_reg      <= WPOST;
                        cnt_reg        <= CNT_W'(WR_POST_CYC);
                        drive_data_reg <= 1'b0;
                        data_pos_reg   <= '0;
                        data_neg_reg   <= '0;
                    end else begin
                        beat_reg     <= beat_reg + 2'd1;
                        data_pos_reg <= wd_reg[3:0];
                        data_neg_reg <= wd_reg[7:4];
                        wd_reg       <= wd_reg >> 8;
                    end
                end
                WPOST: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg        <= IDLE;
                        drive_enable_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RWAIT: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= RCAPT;
                        beat_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                RCAPT: begin
                    shadow_reg <= capt_word[31:8];
                    if (last_beat) begin
                        state_reg    <= RDONE;
                        rd_data_reg  <= bl4_reg ? {16'h0000, capt_word[31:16]} : capt_word;
                        rd_valid_reg <= 1'b1;
                        dqs_read_reg <= 1'b0;
                    end else begin
                        beat_reg <= beat_reg + 2'd1;
                    end
                end
                RDONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ack            = accept_wr;
    assign bus.rd_ack            = accept_rd;
    assign bus.rd_data           = rd_data_reg;
    assign bus.rd_valid          = rd_valid_reg;
    assign bus.busy              = (state_reg != IDLE);
    assign data_pos              = data_pos_reg;
    assign data_neg              = data_neg_reg;
    assign dram_io_drive_enable  = drive_enable_reg;
    assign dram_io_drive_data    = drive_data_reg;
    assign dqs_read              = dqs_read_reg;

`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
    logic [31:0] lb_word_reg;
    logic        lb_mismatch_reg;

    // rd_data_reg already holds the freshly assembled word during RDONE.
    always_ff @(posedge rclk) begin
        if (rst) begin
            lb_word_reg     <= '0;
            lb_mismatch_reg <= 1'b0;
        end else begin
            if (accept_wr) begin
                lb_word_reg <= bus.burst_length_four ? {16'h0000, bus.wr_data[15:0]} : bus.wr_data;
            end
            if ((state_reg == RDONE) && (rd_data_reg != lb_word_reg)) begin
                lb_mismatch_reg <= 1'b1;
            end
        end
    end

    assign lb_mismatch = lb_mismatch_reg;
`endif

endmodule

// File: tb/tb_dram_io_nibble_seq.sv
// Directed bench for dram_io_nibble_seq: per-cycle vector table plus hand sequences
// for request priority, reset mid-burst and the optional loopback check.
module tb_dram_io_nibble_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din, dhi;
    logic [3:0] dpos, dneg;
    logic       den, ddat, dqs;
`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
    logic       lb_mismatch;
`endif

    int n_pass  = 0;
    int n_total = 0;

    dram_io_nibble_seq_if bus ();

    dram_io_nibble_seq dut (
        .rclk                 (clk),
        .rst                  (rst),
        .bus                  (bus),
        .io_dram_data_in      (din),
        .io_dram_data_in_hi   (dhi),
        .data_pos             (dpos),
        .data_neg             (dneg),
        .dram_io_drive_enable (den),
        .dram_io_drive_data   (ddat),
        .dqs_read             (dqs)
`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
        ,
        .lb_mismatch          (lb_mismatch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr, rd, blf;
        logic [31:0] wd;
        logic [3:0]  lat, pin, phi;
        logic        e_wack, e_rack, e_busy, e_den, e_ddat, e_dqs, e_rv;
        logic [3:0]  e_pos, e_neg;
        logic [31:0] e_rdat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic wr, input logic rd, input logic blf, input logic [31:0] wd,
        input logic [3:0] lat, input logic [3:0] pin, input logic [3:0] phi,
        input logic wack, input logic rack, input logic busy, input logic e_den,
        input logic e_ddat, input logic e_dqs, input logic rv,
        input logic [3:0] pos, input logic [3:0] neg, input logic [31:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.blf = blf; v.wd = wd; v.lat = lat; v.pin = pin; v.phi = phi;
        v.e_wack = wack; v.e_rack = rack; v.e_busy = busy; v.e_den = e_den;
        v.e_ddat = e_ddat; v.e_dqs = e_dqs; v.e_rv = rv;
        v.e_pos = pos; v.e_neg = neg; v.e_rdat = rdat;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return {17'b0, bus.wr_ack, bus.rd_ack, bus.busy, den, ddat, dqs, bus.rd_valid,
                dpos, dneg, bus.rd_data};
    endfunction

    function automatic logic [63:0] exp_outs(input vec_t v);
        return {17'b0, v.e_wack, v.e_rack, v.e_busy, v.e_den, v.e_ddat, v.e_dqs, v.e_rv,
                v.e_pos, v.e_neg, v.e_rdat};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) begin
            n_pass++;
            $display("chk %-18s ok   value=%h", name, act);
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w, input int nb);
        for (int b = 0; b < nb; b++) begin
            din = w[8*b +: 4];
            dhi = w[8*b+4 +: 4];
            cyc();
        end
        din = 4'h0;
        dhi = 4'h0;
    endtask

    initial begin
        int n_wait;
        logic seen;

        rst = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.burst_length_four = 1'b0;
        bus.wr_data = '0; bus.rd_lat = '0; din = '0; dhi = '0;

        // ---- write BL4, A5C3
        tbl.push_back(mk(1,0,1,32'h0000A5C3,4'h0,4'h0,4'h0, 1,0,0,0,0,0,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h0,4'h0,4'h0, 0,0,1,1,0,0,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h0,4'h0,4'h0, 0,0,1,1,1,0,0, 4'h3,4'hC,32'h0));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h0,4'h0,4'h0, 0,0,1,1,1,0,0, 4'h5,4'hA,32'h0));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h0,4'h0,4'h0, 0,0,1,1,0,0,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h0,4'h0,4'h0, 0,0,0,0,0,0,0, 4'h0,4'h0,32'h0));
        // ---- read BL8, rd_lat=3
        tbl.push_back(mk(0,1,0,32'hFFFFFFFF,4'h3,4'hF,4'hF, 0,1,0,0,0,0,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(1,0,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'h1,4'h2, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'h3,4'h4, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'h5,4'h6, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'h7,4'h8, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h0));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,0,1,0,0,0,1, 4'h0,4'h0,32'h87654321));
        tbl.push_back(mk(0,0,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,0,0,0,0,0,0, 4'h0,4'h0,32'h87654321));
        // ---- zero-latency read BL4
        tbl.push_back(mk(0,1,1,32'hFFFFFFFF,4'h0,4'hF,4'hF, 0,1,0,0,0,0,0, 4'h0,4'h0,32'h87654321));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h5,4'h9,4'hA, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h87654321));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h5,4'hB,4'hC, 0,0,1,0,0,1,0, 4'h0,4'h0,32'h87654321));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h5,4'hF,4'hF, 0,0,1,0,0,0,1, 4'h0,4'h0,32'h0000CBA9));
        tbl.push_back(mk(0,0,0,32'hFFFFFFFF,4'h5,4'hF,4'hF, 0,0,0,0,0,0,0, 4'h0,4'h0,32'h0000CBA9));

        // ---- reset state
        cyc();
        cyc();
        #4;
        chk("reset_outputs", outs(), 64'h0);
        cyc();
        rst = 1'b0;

        foreach (tbl[i]) begin
            bus.wr_req = tbl[i].wr; bus.rd_req = tbl[i].rd;
            bus.burst_length_four = tbl[i].blf; bus.wr_data = tbl[i].wd;
            bus.rd_lat = tbl[i].lat; din = tbl[i].pin; dhi = tbl[i].phi;
            #4;
            chk($sformatf("vec%0d", i), outs(), exp_outs(tbl[i]));
            cyc();
        end
        bus.rd_lat = 4'h0; din = 4'h0; dhi = 4'h0;

        // ---- simultaneous request: write wins, read accepted in first IDLE after WPOST
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.burst_length_four = 1'b0;
        bus.wr_data = 32'h12345678; bus.rd_lat = 4'h2;
        #4;
        chk("simul_acks", {62'b0, bus.wr_ack, bus.rd_ack}, 64'h2);
        cyc();
        bus.wr_req = 1'b0;
        n_wait = 0;
        for (int k = 1; k <= 20; k++) begin
            #4;
            if (bus.rd_ack) begin
                n_wait = k;
                break;
            end
            cyc();
        end
        chk("simul_rd_ack_delay", 64'(n_wait), 64'd7);
        cyc();
        bus.rd_req = 1'b0;
        cyc();
        cyc();
        feed(32'h12345678, 4);
        #4;
        chk("simul_rd_valid", {31'b0, bus.rd_valid, bus.rd_data}, {31'b0, 1'b1, 32'h12345678});
        cyc();
`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
        #4;
        chk("lb_match_clear", {63'b0, lb_mismatch}, 64'h0);
`endif

        // ---- reset during WBURST beat 1 of a BL8 write
        bus.wr_req = 1'b1; bus.burst_length_four = 1'b0; bus.wr_data = 32'hDEADBEEF;
        #4;
        chk("rstmid_ack", {63'b0, bus.wr_ack}, 64'h1);
        cyc();
        bus.wr_req = 1'b0;
        cyc();
        #4;
        chk("rstmid_beat0", {56'b0, den, ddat, 2'b0, dpos}, {56'b0, 2'b11, 2'b0, 4'hF});
        chk("rstmid_beat0_neg", {60'b0, dneg}, 64'hE);
        cyc();
        rst = 1'b1;
        #4;
        chk("rstmid_beat1", {56'b0, dpos, dneg}, 64'hEB);
        cyc();
        rst = 1'b0;
        #4;
        chk("rstmid_outputs", outs(), 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            #4;
            if (bus.wr_ack || bus.busy || den) seen = 1'b1;
        end
        chk("rstmid_quiet", {63'b0, seen}, 64'h0);
        cyc();

`ifdef DRAM_IO_SEQ_LOOPBACK_CHK_EN
        // ---- loopback mismatch: write 12345678, read back 12345679
        bus.wr_req = 1'b1; bus.burst_length_four = 1'b0; bus.wr_data = 32'h12345678;
        cyc();
        bus.wr_req = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        bus.rd_req = 1'b1; bus.rd_lat = 4'h1;
        #4;
        chk("lb_rd_ack", {63'b0, bus.rd_ack}, 64'h1);
        cyc();
        bus.rd_req = 1'b0;
        cyc();
        feed(32'h12345679, 4);
        #4;
        chk("lb_rd_data", {32'b0, bus.rd_data}, {32'b0, 32'h12345679});
        cyc();
        #4;
        chk("lb_mismatch_set", {63'b0, lb_mismatch}, 64'h1);
        for (int k = 0; k < 3; k++) cyc();
        #4;
        chk("lb_mismatch_sticky", {63'b0, lb_mismatch}, 64'h1);
        cyc();
        rst = 1'b1;
        cyc();
        #4;
        chk("lb_mismatch_rst", {63'b0, lb_mismatch}, 64'h0);
        cyc();
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dram_io_nibble_seq.md
Name: dram_io_nibble_seq

Overview:
- Controller-side burst sequencer for one DDR nibble lane (4 DQ plus DQS). It sits between the DRAM controller datapath and the pad slice.
- Write path: serialises one burst word into per-cycle data_pos/data_neg beats, and drives the pad enable and DQS drive controls with preamble and postamble.
- Read path: opens the dqs_read window after a programmable latency, then gathers io_dram_data_in and io_dram_data_in_hi beats into one burst word with a valid pulse.

Parameters:
- MAX_RD_LAT, 15: largest legal rd_lat value. It sets the width of the latency counter.
- WR_POST_CYC, 1: number of postamble cycles after the last write beat. Legal range is 1..3.

Ports:
- rclk  in  1  lane clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high
- burst_length_four  in  1  1 = BL4 (2 data cycles), 0 = BL8 (4 data cycles); sampled at accept
- wr_req  in  1  write burst request
- wr_data  in  32  burst word; BL4 uses [15:0] only
- wr_ack  out  1  one-cycle pulse in the cycle a write is accepted
- rd_req  in  1  read burst request
- rd_lat  in  4  wait cycles between accept and the first capture; sampled at accept
- rd_ack  out  1  one-cycle pulse in the cycle a read is accepted
- io_dram_data_in  in  4  rising-edge read beat from the pads
- io_dram_data_in_hi  in  4  falling-edge read beat from the pads
- data_pos  out  4  rising-edge write beat to the pads
- data_neg  out  4  falling-edge write beat to the pads
- dram_io_drive_enable  out  1  DQ/DQS output enable
- dram_io_drive_data  out  1  DQS drive level (1 = strobe active)
- dqs_read  out  1  read capture window
- rd_data  out  32  assembled read burst; BL4 fills [15:0] and forces [31:16] to 0
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - All outputs go to 0, including rd_data, wr_ack, rd_ack and rd_valid.
  - An operation in progress is abandoned with no ack or valid.
- FSM states: IDLE, WPRE, WBURST, WPOST, RWAIT, RCAPT, RDONE.
- N = 2 for BL4, 4 for BL8, latched at accept.
- IDLE:
  - Requests are accepted only here, and only when rst=0.
  - wr_req has priority over rd_req. If both are high, the write is accepted and rd_req is ignored; the requester must hold rd_req.
  - On write accept: wr_ack=1, wr_data and BL are latched, next state WPRE.
  - On read accept: rd_ack=1, rd_lat and BL are latched, next state RWAIT, or RCAPT if rd_lat=0.
- WPRE (1 cycle): drive_enable=1, drive_data=0, data_pos/data_neg=0.
- WBURST (N cycles, beat index k=0..N-1):
  - drive_enable=1, drive_data=1.
  - data_pos=wd[8k+3:8k], data_neg=wd[8k+7:8k+4].
- WPOST (WR_POST_CYC cycles): drive_enable=1, drive_data=0, data=0. Then go to IDLE.
- RWAIT:
  - dqs_read=1.
  - Counter loads rd_lat at accept and decrements each cycle.
  - Exit to RCAPT when the count reaches 1, so exactly rd_lat cycles are spent in RWAIT.
- RCAPT (N cycles, k=0..N-1):
  - dqs_read=1.
  - On the edge ending cycle k: shadow[8k+3:8k]=io_dram_data_in, shadow[8k+7:8k+4]=io_dram_data_in_hi.
- RDONE (1 cycle):
  - rd_data=shadow, with the upper half zeroed for BL4.
  - rd_valid=1, dqs_read=0, then go to IDLE.
  - rd_data holds its value until the next RDONE.
- In every state other than those named above, drive_enable, drive_data and dqs_read are 0. drive_enable and dqs_read are never both 1.
- Latency:
  - Write: first beat appears 2 cycles after the wr_ack cycle. Total occupancy is 1+1+N+WR_POST_CYC cycles.
  - Read: rd_valid appears rd_lat+N+1 cycles after the rd_ack cycle.
- Back-to-back operations: the next accept is possible in the first IDLE cycle after WPOST or RDONE. There is no idle gap other than that IDLE cycle.
- Requests or input changes outside IDLE have no effect.

Optional Feature:
- Macro: DRAM_IO_SEQ_LOOPBACK_CHK_EN.
- When defined:
  - An extra output, lb_mismatch (1 bit), is added.
  - The last accepted wr_data, with the BL4 upper half masked, is kept.
  - At each RDONE, the new rd_data is compared with that stored word; any difference sets lb_mismatch.
  - lb_mismatch is sticky and cleared only by rst.
- When undefined: the port and the storage are absent, and all other behaviour is identical.

Test Plan:
- Write, BL4: burst_length_four=1, wr_data=32'h0000_A5C3, wr_req pulsed.
  - Expect: wr_ack, then WPRE, then data_pos/neg = 3/C then 5/A.
  - Then one postamble cycle, drive_enable high for exactly 4 cycles.
- Read, BL8: rd_lat=3, pads present (in,hi) = (1,2),(3,4),(5,6),(7,8).
  - Expect: dqs_read high for 7 cycles.
  - Expect: rd_valid 8 cycles after rd_ack with rd_data=32'h8765_4321.
- Simultaneous request: wr_req=rd_req=1 in IDLE.
  - Expect: write accepted first.
  - Expect: with rd_req held, rd_ack in the first IDLE cycle after WPOST.
- Zero latency: rd_lat=0, BL4.
  - Expect: capture starts the cycle after rd_ack, rd_valid 3 cycles after rd_ack, rd_data[31:16]=0.
- Reset mid-burst: assert rst during WBURST beat 1.
  - Expect: next cycle all outputs are 0, busy=0, and no wr_ack is repeated.
- With DRAM_IO_SEQ_LOOPBACK_CHK_EN: write 32'h1234_5678, then read back 32'h1234_5679.
  - Expect: lb_mismatch=1 after RDONE, staying 1 until rst.
